// File: rtl/run_det_sched.sv
// Round-robin shared run-of-ones detector: req->gnt 1 cycle, bits accepted only while STREAM,
// per-frame hit/hit_cnt reported with a done pulse (or abort pulse if the requester drops req).
module run_det_sched #(
  parameter int N_REQ   = 4,
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             bit_last,
  output logic             bit_ready,
  output logic             det,
  output logic             done,
  output logic             abort,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [ID_W-1:0]  done_id,
  output logic             busy
);
  localparam int RC_W = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {IDLE, STREAM, REPORT} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [RC_W-1:0]    run_cnt_q, run_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;

  logic               found, found_hi, found_lo;
  logic [ID_W-1:0]    pick, pick_hi, pick_lo, next_id;
  logic               accept, req_lost;

  assign accept   = bit_valid && (state_q == STREAM);
  assign req_lost = !req[done_id_q];
  assign next_id  = (done_id_q == ID_W'(N_REQ - 1)) ? '0 : done_id_q + 1'b1;

  // Prefer the lowest requester at or above rr_ptr, else wrap to the lowest overall.
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    found_lo = 1'b0;
    pick_lo  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (req[j] && !found_hi && (ID_W'(j) >= rr_ptr_q)) begin
        found_hi = 1'b1;
        pick_hi  = ID_W'(j);
      end
      if (req[j] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = ID_W'(j);
      end
    end
    found = found_lo;
    pick  = found_hi ? pick_hi : pick_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      run_cnt_q <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      hit_q     <= 1'b0;
      hit_cnt_q <= '0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      run_cnt_q <= run_cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      hit_q     <= hit_d;
      hit_cnt_q <= hit_cnt_d;
      done_id_q <= done_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = STREAM;
      STREAM: begin
        if (accept && bit_last)      state_d = REPORT;
        else if (req_lost && !accept) state_d = IDLE;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    run_cnt_d = run_cnt_q;
    gnt_d     = gnt_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    hit_d     = hit_q;
    hit_cnt_d = hit_cnt_q;
    done_id_d = done_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          done_id_d   = pick;
          run_cnt_d   = '0;
          hit_d       = 1'b0;
          hit_cnt_d   = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (bit_in) begin
            if (run_cnt_q != RC_W'(RUN_LEN)) run_cnt_d = run_cnt_q + 1'b1;
            // The 1 that completes a run is the only one that counts it.
            if (run_cnt_q == RC_W'(RUN_LEN - 1)) begin
              hit_d = 1'b1;
              if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
            end
          end else begin
            run_cnt_d = '0;
          end
          if (bit_last) begin
            gnt_d  = '0;
            done_d = 1'b1;
          end
        end else if (req_lost) begin
          gnt_d     = '0;
          abort_d   = 1'b1;
          rr_ptr_d  = next_id;
          run_cnt_d = '0;
          hit_d     = 1'b0;
          hit_cnt_d = '0;
        end
      end
      REPORT:  rr_ptr_d = next_id;
      default: ;
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    bit_ready = (state_q == STREAM);
    busy      = (state_q != IDLE);
    det       = (run_cnt_q == RC_W'(RUN_LEN));
    done      = done_q;
    abort     = abort_q;
    hit       = hit_q;
    hit_cnt   = hit_cnt_q;
    done_id   = done_id_q;
  end
endmodule

// File: tb/tb_run_det_sched.sv
// Randomized scoreboard bench for run_det_sched: driver pushes expected frame results,
// a negedge monitor pops them whenever done/abort pulses.
module tb_run_det_sched;
  localparam int N_REQ   = 4;
  localparam int RUN_LEN = 2;
  localparam int CNT_W   = 8;
  localparam int ID_W    = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             bit_valid, bit_in, bit_last, bit_ready;
  logic             det, done, abort, hit, busy;
  logic [CNT_W-1:0] hit_cnt;
  logic [ID_W-1:0]  done_id;

  run_det_sched #(.N_REQ(N_REQ), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_last(bit_last), .bit_ready(bit_ready),
    .det(det), .done(done), .abort(abort), .hit(hit), .hit_cnt(hit_cnt),
    .done_id(done_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_abort;
    int id;
    bit hit;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   rr_m   = 0;
  bit   fbits[0:1023];
  int   flen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count maximal runs of ones of at least RUN_LEN in the first n frame bits.
  function automatic int count_runs(input int n);
    int len = 0;
    int r = 0;
    for (int i = 0; i < n; i++) begin
      if (fbits[i]) len++;
      else begin
        if (len >= RUN_LEN) r++;
        len = 0;
      end
    end
    if (len >= RUN_LEN) r++;
    return r;
  endfunction

  task automatic load(input logic [31:0] pat, input int n);
    flen = n;
    for (int i = 0; i < n; i++) fbits[i] = pat[n-1-i];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_ready"}, bit_ready, 0);
    chk({tag, "_det"}, det, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_abort"}, abort, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_hit_cnt"}, hit_cnt, 0);
    chk({tag, "_done_id"}, done_id, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called with the DUT idle; returns with the DUT idle and req low.
  task automatic run_frame(input logic [3:0] mask, input int abort_after, input bit gaps);
    int   idx = -1;
    int   ones = 0;
    int   runs;
    bit   is_ab;
    exp_t e;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx < 0 && mask[(rr_m + i) % N_REQ]) idx = (rr_m + i) % N_REQ;
    end
    is_ab = (abort_after >= 0);
    runs  = count_runs(flen);
    req = mask;
    tick();
    chk("gnt", gnt, 32'(1) << idx);
    chk("busy_on_grant", busy, 1);
    for (int i = 0; i < flen; i++) begin
      if (is_ab && i == abort_after) break;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bit_valid = 1'b0;
          bit_in    = 1'($urandom);
          tick();
        end
      end
      bit_valid = 1'b1;
      bit_in    = fbits[i];
      bit_last  = (!is_ab && i == flen - 1);
      ones      = fbits[i] ? ones + 1 : 0;
      if (bit_last) begin
        e.is_abort = 1'b0;
        e.id       = idx;
        e.hit      = (runs > 0);
        e.cnt      = (runs > CNT_MAX) ? CNT_MAX : runs;
        sbq.push_back(e);
      end
      tick();
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      chk("det", det, (ones >= RUN_LEN) ? 1 : 0);
    end
    if (is_ab) begin
      req[idx]   = 1'b0;
      e.is_abort = 1'b1;
      e.id       = idx;
      e.hit      = 1'b0;
      e.cnt      = 0;
      sbq.push_back(e);
      tick();
      chk("gnt_after_abort", gnt, 0);
      chk("busy_after_abort", busy, 0);
    end else begin
      chk("gnt_drop_last", gnt, 0);
      chk("ready_drop_last", bit_ready, 0);
      req = '0;
      tick();
      chk("gnt_report_gap", gnt, 0);
      chk("busy_idle", busy, 0);
    end
    req  = '0;
    rr_m = (idx + 1) % N_REQ;
  endtask

  always @(negedge clk) begin
    exp_t m;
    if (!rst && (done || abort)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse done=%0b abort=%0b expected=none", done, abort);
      end else begin
        m = sbq.pop_front();
        chk("pulse_abort", abort, m.is_abort);
        chk("pulse_done", done, !m.is_abort);
        chk("done_id", done_id, m.id);
        chk("hit", hit, m.hit);
        chk("hit_cnt", hit_cnt, m.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Round robin with every requester pending, one-bit frames.
    for (int k = 0; k < 5; k++) begin
      load(32'($urandom_range(0, 1)), 1);
      run_frame(4'b1111, -1, 1'b0);
    end

    load(32'b0111011, 7);
    run_frame(4'($urandom_range(1, 15)), -1, 1'b0);
    run_frame(4'($urandom_range(1, 15)), -1, 1'b1);
    load(32'b1010, 4);
    run_frame(4'($urandom_range(1, 15)), -1, 1'b1);

    // 300 qualifying runs saturate the counter.
    flen = 900;
    for (int i = 0; i < 900; i++) fbits[i] = (i % 3) != 2;
    run_frame(4'($urandom_range(1, 15)), -1, 1'b1);

    load(32'b11011, 5);
    run_frame(4'b0100, 2, 1'b0);
    load(32'b110, 3);
    run_frame(4'b1111, -1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      flen = $urandom_range(1, 24);
      for (int i = 0; i < flen; i++) fbits[i] = ($urandom_range(0, 2) != 0);
      run_frame(4'($urandom_range(1, 15)),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, flen - 1) : -1,
                1'($urandom));
    end

    // Reset mid-frame: leave rr at 2, grant 2, stream 3 bits, then reset.
    load(32'b1, 1);
    run_frame(4'b0010, -1, 1'b0);
    req = 4'b0100;
    tick();
    chk("pre_reset_gnt", gnt, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    rr_m = 0;
    req  = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    load(32'b1, 1);
    run_frame(4'b0101, -1, 1'b0);
    run_frame(4'b0100, -1, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
